// File: rtl/hazard_pipeline_cpu.sv
// Five-stage in-order pipeline (IF/ID/EX/MEM/WB) with EX-stage operand forwarding
// and a one-cycle load-use interlock; the register file write is mirrored on wb_*.
module hazard_pipeline_cpu #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int DM_AW  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_data,
  output logic [DM_AW-1:0]  dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_en,
  output logic [RA_W-1:0]   wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int NREG   = 1 << RA_W;
  localparam int STAGES = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_SLT = 6'h2A, FN_SLL = 6'h00;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL} alu_e;

  typedef struct packed {
    logic            we;
    logic            mrd;
    logic            mwr;
    logic            use_imm;
    alu_e            op;
    logic [RA_W-1:0] dst;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             c;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
  } idex_t;

  typedef struct packed {
    logic              we;
    logic              mrd;
    logic              mwr;
    logic [RA_W-1:0]   dst;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] sd;
  } exmem_t;

  typedef struct packed {
    logic              we;
    logic [RA_W-1:0]   dst;
    logic [DATA_W-1:0] data;
  } memwb_t;

  logic [31:0]       pc;
  logic [31:0]       ifid_instr;
  idex_t             idex;
  exmem_t            exmem;
  memwb_t            memwb;
  logic [STAGES:1]   vld_pipe;
  logic [DATA_W-1:0] rf [NREG];

  // ---------------- ID ----------------
  logic [5:0]        id_op, id_fn;
  logic [RA_W-1:0]   id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_imm, id_a, id_b;
  logic              id_uses_rt, stall;
  ctrl_t             id_c;

  assign id_op  = ifid_instr[31:26];
  assign id_fn  = ifid_instr[5:0];
  assign id_rs  = RA_W'(ifid_instr[25:21]);
  assign id_rt  = RA_W'(ifid_instr[20:16]);
  assign id_rd  = RA_W'(ifid_instr[15:11]);
  assign id_imm = {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};

  always_comb begin
    id_c = '0;
    case (id_op)
      OP_RTYPE: begin
        id_c.we  = 1'b1;
        id_c.dst = id_rd;
        case (id_fn)
          FN_ADD:  id_c.op = ALU_ADD;
          FN_SUB:  id_c.op = ALU_SUB;
          FN_AND:  id_c.op = ALU_AND;
          FN_OR:   id_c.op = ALU_OR;
          FN_SLT:  id_c.op = ALU_SLT;
          FN_SLL:  id_c.op = ALU_SLL;
          default: id_c.we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        id_c.we = 1'b1; id_c.use_imm = 1'b1; id_c.dst = id_rt;
      end
      OP_LW: begin
        id_c.we = 1'b1; id_c.mrd = 1'b1; id_c.use_imm = 1'b1; id_c.dst = id_rt;
      end
      OP_SW: begin
        id_c.mwr = 1'b1; id_c.use_imm = 1'b1;
      end
      default: ;
    endcase
    if (id_c.dst == '0) id_c.we = 1'b0;
    if (!vld_pipe[1])   id_c = '0;
  end

  // Write-first read: the value retiring this cycle is visible to the decoder.
  assign id_a = (id_rs == '0) ? '0 : (wb_en && wb_addr == id_rs) ? wb_data : rf[id_rs];
  assign id_b = (id_rt == '0) ? '0 : (wb_en && wb_addr == id_rt) ? wb_data : rf[id_rt];

  assign id_uses_rt = (id_op == OP_RTYPE) || (id_op == OP_SW);
  assign stall = vld_pipe[1] && vld_pipe[2] && idex.c.mrd && (idex.c.dst != '0) &&
                 ((idex.c.dst == id_rs) || (id_uses_rt && idex.c.dst == id_rt));

  // ---------------- EX ----------------
  logic [DATA_W-1:0] ex_a, ex_b, op_b, ex_res;

  // A load in EX/MEM never feeds EX directly: the interlock guarantees a bubble there.
  always_comb begin
    ex_a = idex.a;
    if (idex.rs != '0 && exmem.we && !exmem.mrd && exmem.dst == idex.rs) ex_a = exmem.res;
    else if (idex.rs != '0 && wb_en && wb_addr == idex.rs)               ex_a = wb_data;
    ex_b = idex.b;
    if (idex.rt != '0 && exmem.we && !exmem.mrd && exmem.dst == idex.rt) ex_b = exmem.res;
    else if (idex.rt != '0 && wb_en && wb_addr == idex.rt)               ex_b = wb_data;
  end

  assign op_b = idex.c.use_imm ? idex.imm : ex_b;

  always_comb begin
    case (idex.c.op)
      ALU_SUB: ex_res = ex_a - op_b;
      ALU_AND: ex_res = ex_a & op_b;
      ALU_OR:  ex_res = ex_a | op_b;
      ALU_SLT: ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(op_b))};
      ALU_SLL: ex_res = ex_b << idex.shamt;
      default: ex_res = ex_a + op_b;
    endcase
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      ifid_instr <= '0;
      idex       <= '0;
      exmem      <= '0;
      memwb      <= '0;
      vld_pipe   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[3], vld_pipe[2], vld_pipe[1] & ~stall, 1'b1};
      if (!stall) begin
        pc         <= pc + 32'd4;
        ifid_instr <= imem_data;
      end
      idex.c     <= stall ? '0 : id_c;
      idex.rs    <= id_rs;
      idex.rt    <= id_rt;
      idex.shamt <= ifid_instr[10:6];
      idex.a     <= id_a;
      idex.b     <= id_b;
      idex.imm   <= id_imm;
      exmem.we   <= idex.c.we;
      exmem.mrd  <= idex.c.mrd;
      exmem.mwr  <= idex.c.mwr;
      exmem.dst  <= idex.c.dst;
      exmem.res  <= ex_res;
      exmem.sd   <= ex_b;
      memwb.we   <= exmem.we;
      memwb.dst  <= exmem.dst;
      memwb.data <= exmem.mrd ? dmem_rdata : exmem.res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign imem_addr  = pc;
  assign dmem_addr  = exmem.res[DM_AW-1:0];
  assign dmem_wdata = exmem.sd;
  assign dmem_we    = vld_pipe[3] & exmem.mwr;
  assign dmem_re    = vld_pipe[3] & exmem.mrd;
  assign wb_en      = vld_pipe[4] & memwb.we;
  assign wb_addr    = memwb.dst;
  assign wb_data    = memwb.data;

endmodule

// File: tb/tb_hazard_pipeline_cpu.sv
// Scoreboard bench: an in-order ISA model predicts retire/store/load streams,
// a negedge monitor pops and compares whatever the pipeline presents.
module tb_hazard_pipeline_cpu;
  localparam int DATA_W = 32, RA_W = 5, DM_AW = 7;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [31:0]       imem_addr, imem_data;
  logic [DM_AW-1:0]  dmem_addr;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata, wb_data;
  logic              dmem_we, dmem_re, wb_en;
  logic [RA_W-1:0]   wb_addr;

  hazard_pipeline_cpu #(.DATA_W(DATA_W), .RA_W(RA_W), .DM_AW(DM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data));

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] dm [32];
  logic [31:0] dm_init [32];
  logic        dm_load = 1'b0;
  int          cyc = 0;

  assign imem_data  = (imem_addr[31:10] == 22'd0) ? imem[imem_addr[9:2]] : 32'd0;
  assign dmem_rdata = dm[dmem_addr[6:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dm_load) for (int i = 0; i < 32; i++) dm[i] <= dm_init[i];
    else if (dmem_we) dm[dmem_addr[6:2]] <= dmem_wdata;
  end

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wb_t;
  typedef struct packed { logic [6:0] a; logic [31:0] d; } st_t;
  wb_t        exp_wb[$];
  st_t        exp_st[$];
  logic [6:0] exp_ld[$];
  int         wb_cyc[$];
  int         n_chk = 0, n_fail = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endfunction

  function automatic void unexpected(string nm, logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h, required no event", nm, act);
  endfunction

  // Monitor: compares every DUT event against the head of its queue.
  always @(negedge clk) begin : mon
    wb_t e; st_t s; logic [6:0] la;
    if (wb_en) begin
      wb_cyc.push_back(cyc);
      if (exp_wb.size() == 0) unexpected("wb unexpected", {wb_addr, wb_data});
      else begin
        e = exp_wb.pop_front();
        chk("wb addr", 64'(wb_addr), 64'(e.a));
        chk("wb data", 64'(wb_data), 64'(e.d));
      end
    end
    if (dmem_we) begin
      if (exp_st.size() == 0) unexpected("store unexpected", {dmem_addr, dmem_wdata});
      else begin
        s = exp_st.pop_front();
        chk("store addr", 64'(dmem_addr), 64'(s.a));
        chk("store data", 64'(dmem_wdata), 64'(s.d));
      end
    end
    if (dmem_re) begin
      if (exp_ld.size() == 0) unexpected("load unexpected", 64'(dmem_addr));
      else begin
        la = exp_ld.pop_front();
        chk("load addr", 64'(dmem_addr), 64'(la));
      end
    end
  end

  function automatic logic [31:0] rtype(int fn, int rd, int rs, int rt, int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] itype(int op, int rt, int rs, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Architectural model: executes the program sequentially, no notion of stages.
  task automatic model_build(input int n);
    logic [31:0] r [32];
    logic [31:0] m [32];
    logic [31:0] ins, se, v, ea;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic [5:0]  op, fn;
    logic        wr;
    for (int i = 0; i < 32; i++) begin r[i] = 0; m[i] = dm_init[i]; end
    exp_wb.delete(); exp_st.delete(); exp_ld.delete();
    for (int k = 0; k < n; k++) begin
      ins = imem[k];
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      sh = ins[10:6];  fn = ins[5:0];   se = {{16{ins[15]}}, ins[15:0]};
      wr = 1'b0; dst = 0; v = 0;
      ea = r[rs] + se;
      case (op)
        6'h00: begin
          wr = 1'b1; dst = rd;
          case (fn)
            6'h20: v = r[rs] + r[rt];
            6'h22: v = r[rs] - r[rt];
            6'h24: v = r[rs] & r[rt];
            6'h25: v = r[rs] | r[rt];
            6'h2A: v = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
            6'h00: v = r[rt] << sh;
            default: wr = 1'b0;
          endcase
        end
        6'h08: begin wr = 1'b1; dst = rt; v = ea; end
        6'h23: begin wr = 1'b1; dst = rt; v = m[ea[6:2]]; exp_ld.push_back(ea[6:0]); end
        6'h2B: begin m[ea[6:2]] = r[rt]; exp_st.push_back({ea[6:0], r[rt]}); end
        default: ;
      endcase
      if (wr && dst != 0) begin
        r[dst] = v;
        exp_wb.push_back({dst, v});
      end
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    for (int i = 0; i < 32; i++) dm_init[i] = 32'd0;
  endtask

  // Entered and left at posedge+1 with rst_n low.
  task automatic run_prog(input int n, input string nm);
    dm_load = 1'b1;
    @(posedge clk); #1;
    dm_load = 1'b0;
    model_build(n);
    wb_cyc.delete();
    rst_n = 1'b1;
    repeat (2 * n + 12) @(posedge clk);
    #1 rst_n = 1'b0;
    chk({nm, " wb drained"},    64'(exp_wb.size()), 64'd0);
    chk({nm, " st drained"},    64'(exp_st.size()), 64'd0);
    chk({nm, " ld drained"},    64'(exp_ld.size()), 64'd0);
  endtask

  function automatic void gap_chk(string nm, int idx, int exp);
    int g;
    g = (wb_cyc.size() > idx) ? wb_cyc[idx] - wb_cyc[idx-1] : -1;
    chk(nm, 64'(g), 64'(exp));
  endfunction

  task automatic gen_rand(input int n);
    int kind, rs, rt, rd;
    clear_prog();
    for (int i = 0; i < 32; i++) dm_init[i] = $urandom;
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 11);
      rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
      case (kind)
        0: imem[k] = rtype(8'h20, rd, rs, rt, 0);
        1: imem[k] = rtype(8'h22, rd, rs, rt, 0);
        2: imem[k] = rtype(8'h24, rd, rs, rt, 0);
        3: imem[k] = rtype(8'h25, rd, rs, rt, 0);
        4: imem[k] = rtype(8'h2A, rd, rs, rt, 0);
        5: imem[k] = rtype(8'h00, rd, rs, rt, $urandom_range(0, 31));
        6, 7: imem[k] = itype(8'h08, rt, rs, $urandom_range(0, 65535));
        8, 9: imem[k] = itype(8'h23, rt, rs, $urandom_range(0, 127));
        10: imem[k] = itype(8'h2B, rt, rs, $urandom_range(0, 127));
        default: imem[k] = $urandom_range(0, 1) ? {6'h3F, 26'($urandom)}
                                                : rtype(8'h21, rd, rs, rt, 0);
      endcase
    end
  endtask

  initial begin
    clear_prog();
    repeat (2) @(negedge clk);
    chk("reset imem_addr", 64'(imem_addr), 64'd0);
    chk("reset dmem_we",   64'(dmem_we),   64'd0);
    chk("reset dmem_re",   64'(dmem_re),   64'd0);
    chk("reset wb_en",     64'(wb_en),     64'd0);
    @(posedge clk); #1;

    // Dependent addi/add chain: forwarded, no stall.
    clear_prog();
    imem[0] = itype(8'h08, 1, 0, 5);
    imem[1] = itype(8'h08, 2, 1, 3);
    imem[2] = rtype(8'h20, 3, 1, 2, 0);
    run_prog(3, "chain");
    chk("chain wb count", 64'(wb_cyc.size()), 64'd3);
    gap_chk("chain gap1", 1, 1);
    gap_chk("chain gap2", 2, 1);

    // Load-use: exactly one bubble.
    clear_prog();
    dm_init[0] = 32'h1234;
    imem[0] = itype(8'h23, 4, 0, 0);
    imem[1] = rtype(8'h20, 5, 4, 4, 0);
    run_prog(2, "loaduse");
    gap_chk("loaduse gap", 1, 2);

    // Store data forwarded from the immediately preceding addi.
    clear_prog();
    imem[0] = itype(8'h08, 6, 0, -1);
    imem[1] = itype(8'h2B, 6, 0, 8);
    run_prog(2, "swfwd");

    // Register 0 stays zero and is never reported as written.
    clear_prog();
    imem[0] = itype(8'h08, 0, 0, 7);
    imem[1] = rtype(8'h20, 7, 0, 0, 0);
    run_prog(2, "reg0");
    chk("reg0 wb count", 64'(wb_cyc.size()), 64'd1);

    // Unknown opcode occupies a slot but retires nothing.
    clear_prog();
    imem[0] = itype(8'h08, 1, 0, 1);
    imem[1] = 32'hFC00_0000;
    imem[2] = itype(8'h08, 2, 0, 2);
    run_prog(3, "nop");
    gap_chk("nop gap", 1, 2);

    // Back-to-back load hazards stall once each; a load into $0 never stalls.
    clear_prog();
    dm_init[0] = 32'd4; dm_init[1] = 32'h55; dm_init[2] = 32'h77;
    imem[0] = itype(8'h23, 1, 0, 0);
    imem[1] = itype(8'h23, 2, 1, 0);
    imem[2] = rtype(8'h20, 3, 2, 1, 0);
    imem[3] = itype(8'h08, 9, 0, 1);
    imem[4] = itype(8'h23, 0, 0, 8);
    imem[5] = rtype(8'h20, 8, 0, 0, 0);
    run_prog(6, "lwlw");
    gap_chk("lwlw gap1", 1, 2);
    gap_chk("lwlw gap2", 2, 2);
    gap_chk("lwlw gap3", 3, 1);
    gap_chk("lw0 nostall", 4, 2);

    // Reset while a store sits in EX.
    clear_prog();
    imem[0] = itype(8'h08, 1, 0, 9);
    imem[1] = itype(8'h2B, 1, 0, 4);
    exp_wb.delete(); exp_st.delete(); exp_ld.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midreset dmem_we", 64'(dmem_we), 64'd0);
      chk("midreset wb_en",   64'(wb_en),   64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("refetch pc0", 64'(imem_addr), 64'd0);
    @(negedge clk); chk("refetch pc1", 64'(imem_addr), 64'd4);
    @(negedge clk); chk("refetch pc2", 64'(imem_addr), 64'd8);
    @(posedge clk); #1 rst_n = 1'b0;

    for (int t = 0; t < 6; t++) begin
      gen_rand(40);
      run_prog(40, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
